// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle sequencer for a small MIPS datapath
// (add, sub, jr, ori, lui, beq, lw, sw, jal).
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and shares a
// single memory port between instruction fetch and data access through a
// req/ack handshake. A watchdog moves the controller to ERR when a memory
// request goes unanswered for too long.
// Optional feature macro: MC_CTRL_PERF_CNT_EN. When it is defined, free-running
// cycle and retire counters are built. When it is undefined, both counter
// ports are tied to zero.
module mc_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [7:0]  NPCOp,
  output logic [7:0]  RegDst,
  output logic [7:0]  RegSrc,
  output logic        RegWrite,
  output logic [7:0]  EXTOp,
  output logic [7:0]  ALUSrc,
  output logic [7:0]  ALUOp,
  output logic        instr_done,
  output logic        illegal,
  output logic        err,
  output logic [2:0]  state,
  output logic [31:0] cycle_cnt,
  output logic [31:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;

  // Watchdog counter just wide enough to hold TIMEOUT_CYCLES.
  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  state_t          state_reg, state_next;
  logic [WD_W-1:0] wd_reg, wd_next;
  logic            wd_expire;
  logic            err_reg;

  logic is_add, is_sub, is_jr, is_ori, is_lui, is_beq, is_lw, is_sw, is_jal;
  logic is_legal;

  // Instruction decode from the IR fields; R-type with an unknown funct is illegal.
  always_comb begin
    is_add   = (Op == OP_RTYPE) && (Funct == FN_ADD);
    is_sub   = (Op == OP_RTYPE) && (Funct == FN_SUB);
    is_jr    = (Op == OP_RTYPE) && (Funct == FN_JR);
    is_ori   = (Op == OP_ORI);
    is_lui   = (Op == OP_LUI);
    is_beq   = (Op == OP_BEQ);
    is_lw    = (Op == OP_LW);
    is_sw    = (Op == OP_SW);
    is_jal   = (Op == OP_JAL);
    is_legal = is_add | is_sub | is_jr | is_ori | is_lui |
               is_beq | is_lw | is_sw | is_jal;
  end

  // Watchdog: count consecutive unanswered request cycles and flag expiry.
  // Only FETCH and MEM issue requests, so the count is driven from the state.
  always_comb begin
    wd_next   = '0;
    wd_expire = 1'b0;
    if ((TIMEOUT_CYCLES != 0) &&
        ((state_reg == S_FETCH) || (state_reg == S_MEM)) && !mem_ack) begin
      wd_next   = wd_reg + 1'b1;
      wd_expire = (wd_next == WD_LIMIT);
    end
  end

  // Next-state and datapath control decode (Moore per instruction).
  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    NPCOp      = 8'd0;
    RegDst     = 8'd0;
    RegSrc     = 8'd0;
    RegWrite   = 1'b0;
    EXTOp      = 8'd0;
    ALUSrc     = 8'd0;
    ALUOp      = 8'd0;
    illegal    = 1'b0;

    // ALU and extender selects are set up in EXEC and held through MEM/WB.
    if ((state_reg == S_EXEC) || (state_reg == S_MEM) || (state_reg == S_WB)) begin
      if (is_sub || is_beq) ALUOp = 8'd1;
      if (is_ori)           ALUOp = 8'd2;
      if (is_ori || is_lw || is_sw) ALUSrc = 8'd1;
      if (is_lw || is_sw || is_beq) EXTOp = 8'd1;
      if (is_lui)           EXTOp = 8'd2;
    end

    case (state_reg)
      S_FETCH: begin
        mem_req = 1'b1;
        IorD    = 1'b0;
        IRWrite = mem_ack;
        if (mem_ack) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (is_jr) begin
          PCWrite    = 1'b1;
          NPCOp      = 8'd3;
          state_next = S_FETCH;
        end else if (is_jal) begin
          state_next = S_WB;
        end else if (!is_legal) begin
          // Unknown opcode retires as a nop: just step the PC.
          PCWrite    = 1'b1;
          NPCOp      = 8'd0;
          illegal    = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          PCWrite    = 1'b1;
          NPCOp      = Zero ? 8'd1 : 8'd0;
          state_next = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        mem_we  = is_sw;
        if (mem_ack) begin
          if (is_sw) begin
            PCWrite    = 1'b1;
            NPCOp      = 8'd0;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        PCWrite    = 1'b1;
        state_next = S_FETCH;
        if (is_add || is_sub) begin
          RegDst = 8'd1;
          RegSrc = 8'd0;
        end else if (is_lui) begin
          RegSrc = 8'd2;
        end else if (is_lw) begin
          RegSrc = 8'd1;
        end else if (is_jal) begin
          RegDst = 8'd2;
          RegSrc = 8'd3;
          NPCOp  = 8'd2;
        end
      end
      S_ERR: begin
        state_next = S_ERR;
      end
      default: begin
        state_next = S_ERR;
      end
    endcase

    // An expired watchdog overrides whatever the handshake state wanted.
    if (wd_expire) state_next = S_ERR;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_FETCH;
    else       state_reg <= state_next;
  end

  // Watchdog register: restarts whenever the state moves on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        wd_reg <= '0;
    else if (state_next != state_reg) wd_reg <= '0;
    else                              wd_reg <= wd_next;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    err_reg <= 1'b0;
    else if (state_next == S_ERR) err_reg <= 1'b1;
  end

  assign instr_done = PCWrite;
  assign err        = err_reg;
  assign state      = state_reg;

`ifdef MC_CTRL_PERF_CNT_EN
  // Index 0 counts live cycles, index 1 counts retired instructions.
  logic [1:0]       cnt_inc;
  logic [1:0][31:0] cnt_val;

  assign cnt_inc[0] = (state_reg != S_ERR);
  assign cnt_inc[1] = instr_done;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [31:0] cnt_reg;

    // Wrapping 32-bit event counter.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)            cnt_reg <= '0;
      else if (cnt_inc[gi]) cnt_reg <= cnt_reg + 32'd1;
    end

    assign cnt_val[gi] = cnt_reg;
  end

  assign cycle_cnt  = cnt_val[0];
  assign retire_cnt = cnt_val[1];
`else
  assign cycle_cnt  = 32'd0;
  assign retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed, table-driven bench for mc_ctrl (TIMEOUT_CYCLES=4).
module tb_mc_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  Op;
  logic [5:0]  Funct;
  logic        Zero;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        IorD;
  logic        IRWrite;
  logic        PCWrite;
  logic [7:0]  NPCOp;
  logic [7:0]  RegDst;
  logic [7:0]  RegSrc;
  logic        RegWrite;
  logic [7:0]  EXTOp;
  logic [7:0]  ALUSrc;
  logic [7:0]  ALUOp;
  logic        instr_done;
  logic        illegal;
  logic        err;
  logic [2:0]  state;
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;

  mc_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Zero       (Zero),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .NPCOp      (NPCOp),
    .RegDst     (RegDst),
    .RegSrc     (RegSrc),
    .RegWrite   (RegWrite),
    .EXTOp      (EXTOp),
    .ALUSrc     (ALUSrc),
    .ALUOp      (ALUOp),
    .instr_done (instr_done),
    .illegal    (illegal),
    .err        (err),
    .state      (state),
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Results of the most recent run_instr call.
  int          r_cycles;
  logic [31:0] r_trace;
  logic [7:0]  r_npc, r_rdst, r_rsrc, r_aluop, r_alusrc, r_extop;
  int          r_rw_n, r_ill_n, r_we_n, r_pcw_n, r_iord_n, r_done_mis;
  logic [2:0]  r_next_state;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    int          cyc;
    logic [31:0] trace;
    logic [7:0]  npc;
    logic [7:0]  rdst;
    logic [7:0]  rsrc;
    logic [7:0]  aluop;
    logic [7:0]  alusrc;
    logic [7:0]  extop;
    int          rw_n;
    int          ill_n;
    int          we_n;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reset for two clocks, releasing just after a rising edge.
  task automatic do_reset();
    reset   = 1'b1;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Run one instruction from FETCH until retire, with a memory model that
  // acks after fwait (fetch) or dwait (data) unanswered request cycles.
  // Entered and left just after a rising edge.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fwait, input int dwait);
    int req_cnt;
    bit done;
    Op = op; Funct = fn; Zero = z;
    req_cnt = 0; done = 0;
    r_cycles = 0; r_trace = '0;
    r_npc = '0; r_rdst = '0; r_rsrc = '0; r_aluop = '0; r_alusrc = '0; r_extop = '0;
    r_rw_n = 0; r_ill_n = 0; r_we_n = 0; r_pcw_n = 0; r_iord_n = 0; r_done_mis = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      mem_ack = mem_req && (req_cnt >= (IorD ? dwait : fwait));
      @(negedge clk);
      r_trace = {r_trace[27:0], 1'b0, state};
      if (RegWrite) r_rw_n++;
      if (illegal)  r_ill_n++;
      if (mem_we)   r_we_n++;
      if (PCWrite)  r_pcw_n++;
      if (IorD)     r_iord_n++;
      if (PCWrite !== instr_done) r_done_mis++;
      if (instr_done) begin
        done     = 1;
        r_cycles = c;
        r_npc    = NPCOp;
        r_rdst   = RegDst;
        r_rsrc   = RegSrc;
        r_aluop  = ALUOp;
        r_alusrc = ALUSrc;
        r_extop  = EXTOp;
      end
      req_cnt = (mem_req && !mem_ack) ? req_cnt + 1 : 0;
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    r_next_state = state;
    if (!done) $display("FAIL retire_wait: got no retire expected retire within 40 cycles");
  endtask

  initial begin
    logic pcw_seen;
    //            op     fn     z  cyc trace         npc rd rs alu src ext rw ill we
    vecs[0]  = '{6'h00, 6'h20, 0, 4, 32'h0124,  0, 1, 0, 0, 0, 0, 1, 0, 0};  // add
    vecs[1]  = '{6'h00, 6'h22, 0, 4, 32'h0124,  0, 1, 0, 1, 0, 0, 1, 0, 0};  // sub
    vecs[2]  = '{6'h0D, 6'h00, 0, 4, 32'h0124,  0, 0, 0, 2, 1, 0, 1, 0, 0};  // ori
    vecs[3]  = '{6'h0F, 6'h00, 0, 4, 32'h0124,  0, 0, 2, 0, 0, 2, 1, 0, 0};  // lui
    vecs[4]  = '{6'h23, 6'h00, 0, 5, 32'h01234, 0, 0, 1, 0, 1, 1, 1, 0, 0};  // lw
    vecs[5]  = '{6'h2B, 6'h00, 0, 4, 32'h0123,  0, 0, 0, 0, 1, 1, 0, 0, 1};  // sw
    vecs[6]  = '{6'h04, 6'h00, 1, 3, 32'h012,   1, 0, 0, 1, 0, 1, 0, 0, 0};  // beq taken
    vecs[7]  = '{6'h04, 6'h00, 0, 3, 32'h012,   0, 0, 0, 1, 0, 1, 0, 0, 0};  // beq not taken
    vecs[8]  = '{6'h03, 6'h00, 0, 3, 32'h014,   2, 2, 3, 0, 0, 0, 1, 0, 0};  // jal
    vecs[9]  = '{6'h00, 6'h08, 0, 2, 32'h01,    3, 0, 0, 0, 0, 0, 0, 0, 0};  // jr
    vecs[10] = '{6'h3F, 6'h00, 0, 2, 32'h01,    0, 0, 0, 0, 0, 0, 0, 1, 0};  // bad opcode
    vecs[11] = '{6'h00, 6'h21, 0, 2, 32'h01,    0, 0, 0, 0, 0, 0, 0, 1, 0};  // bad funct

    reset = 1'b0; mem_ack = 1'b0; Op = '0; Funct = '0; Zero = 1'b0;

    // Reset applied between clock edges must act immediately.
    #2 reset = 1'b1;
    #1;
    check("rst_state",   32'(state),   32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd1);
    check("rst_iord",    32'(IorD),    32'd0);
    check("rst_mem_we",  32'(mem_we),  32'd0);
    check("rst_irwrite", 32'(IRWrite), 32'd0);
    check("rst_pcwrite", 32'(PCWrite), 32'd0);
    check("rst_cycle",   cycle_cnt,    32'd0);
    check("rst_retire",  retire_cnt,   32'd0);
    mem_ack = 1'b1;
    #1 check("rst_irwrite_ack", 32'(IRWrite), 32'd1);
    @(posedge clk);
    #1 check("rst_hold_state", 32'(state), 32'd0);

    // add / lw (slow data) / beq sequence from a fresh reset.
    do_reset();
    run_instr(6'h00, 6'h20, 1'b0, 0, 0);
    $display("add: cycles=%0d trace=%0h", r_cycles, r_trace);
    check("add_trace",   r_trace,          32'h0124);
    check("add_cycles",  32'(r_cycles),    32'd4);
    check("add_next",    32'(r_next_state), 32'd0);
    check("add_rw",      32'(r_rw_n),      32'd1);
    check("add_regdst",  32'(r_rdst),      32'd1);
    check("add_regsrc",  32'(r_rsrc),      32'd0);
    check("add_pcw",     32'(r_pcw_n),     32'd1);
    check("add_done",    32'(r_done_mis),  32'd0);

    run_instr(6'h23, 6'h00, 1'b0, 0, 3);
    $display("lw slow: cycles=%0d trace=%0h", r_cycles, r_trace);
    check("lw_slow_trace",  r_trace,       32'h01233334);
    check("lw_slow_cycles", 32'(r_cycles), 32'd8);
    check("lw_slow_iord",   32'(r_iord_n), 32'd4);
    check("lw_slow_we",     32'(r_we_n),   32'd0);
    check("lw_slow_regsrc", 32'(r_rsrc),   32'd1);
    check("lw_slow_state",  32'(state),    32'd0);
    check("lw_slow_err",    32'(err),      32'd0);

    run_instr(6'h04, 6'h00, 1'b1, 0, 0);
    $display("beq: cycles=%0d npc=%0d", r_cycles, r_npc);
    check("beq_npc", 32'(r_npc),  32'd1);
    check("beq_rw",  32'(r_rw_n), 32'd0);
`ifdef MC_CTRL_PERF_CNT_EN
    check("perf_retire", retire_cnt, 32'd3);
    check("perf_cycle",  cycle_cnt,  32'd15);
`else
    check("perf_retire_off", retire_cnt, 32'd0);
    check("perf_cycle_off",  cycle_cnt,  32'd0);
`endif

    // Table of zero-wait instructions.
    for (int i = 0; i < NV; i++) begin
      run_instr(vecs[i].op, vecs[i].fn, vecs[i].z, 0, 0);
      $display("vec %0d op=%0h fn=%0h z=%0d: cycles=%0d trace=%0h npc=%0d",
               i, vecs[i].op, vecs[i].fn, vecs[i].z, r_cycles, r_trace, r_npc);
      check($sformatf("v%0d_cycles", i), 32'(r_cycles),     32'(vecs[i].cyc));
      check($sformatf("v%0d_trace", i),  r_trace,           vecs[i].trace);
      check($sformatf("v%0d_npc", i),    32'(r_npc),        32'(vecs[i].npc));
      check($sformatf("v%0d_regdst", i), 32'(r_rdst),       32'(vecs[i].rdst));
      check($sformatf("v%0d_regsrc", i), 32'(r_rsrc),       32'(vecs[i].rsrc));
      check($sformatf("v%0d_aluop", i),  32'(r_aluop),      32'(vecs[i].aluop));
      check($sformatf("v%0d_alusrc", i), 32'(r_alusrc),     32'(vecs[i].alusrc));
      check($sformatf("v%0d_extop", i),  32'(r_extop),      32'(vecs[i].extop));
      check($sformatf("v%0d_rw", i),     32'(r_rw_n),       32'(vecs[i].rw_n));
      check($sformatf("v%0d_ill", i),    32'(r_ill_n),      32'(vecs[i].ill_n));
      check($sformatf("v%0d_we", i),     32'(r_we_n),       32'(vecs[i].we_n));
      check($sformatf("v%0d_pcw", i),    32'(r_pcw_n),      32'd1);
      check($sformatf("v%0d_done", i),   32'(r_done_mis),   32'd0);
      check($sformatf("v%0d_next", i),   32'(r_next_state), 32'd0);
    end

    // Illegal opcode, then a store whose data ack arrives during reset.
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
    $display("illegal: pulses=%0d", r_ill_n);
    check("ill_pulses", 32'(r_ill_n), 32'd1);
    Op = 6'h2B; Funct = 6'h00; mem_ack = 1'b1;
    @(negedge clk);
    check("swr_fetch_ir", 32'(IRWrite), 32'd1);
    @(posedge clk); #1 mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("swr_mem_state", 32'(state),   32'd3);
    check("swr_mem_we",    32'(mem_we),  32'd1);
    check("swr_mem_iord",  32'(IorD),    32'd1);
    check("swr_mem_pcw",   32'(PCWrite), 32'd0);
    #2 reset = 1'b1; mem_ack = 1'b1;
    #1;
    check("swr_rst_state", 32'(state),   32'd0);
    check("swr_rst_req",   32'(mem_req), 32'd1);
    check("swr_rst_iord",  32'(IorD),    32'd0);
    pcw_seen = PCWrite | RegWrite;
    repeat (2) begin
      @(negedge clk);
      pcw_seen = pcw_seen | PCWrite | RegWrite;
    end
    @(posedge clk); #1 reset = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    $display("sw reset: state=%0d mem_req=%0d writes_seen=%0d", state, mem_req, pcw_seen);
    check("swr_after_state", 32'(state),    32'd0);
    check("swr_after_req",   32'(mem_req),  32'd1);
    check("swr_no_write",    32'(pcw_seen), 32'd0);
    @(posedge clk); #1;

    // Watchdog: fetch never acked, ERR after exactly four request cycles.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("wd_wait%0d_state", i), 32'(state),   32'd0);
      check($sformatf("wd_wait%0d_req", i),   32'(mem_req), 32'd1);
      @(posedge clk); #1;
    end
    $display("watchdog: state=%0d err=%0d", state, err);
    check("wd_state",   32'(state),   32'd7);
    check("wd_err",     32'(err),     32'd1);
    check("wd_req_off", 32'(mem_req), 32'd0);
    mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("wd_hold_state", 32'(state),   32'd7);
    check("wd_hold_ir",    32'(IRWrite), 32'd0);
    check("wd_hold_pcw",   32'(PCWrite), 32'd0);
    mem_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    $display("reset in ERR: state=%0d err=%0d", state, err);
    check("wd_rst_state", 32'(state), 32'd0);
    check("wd_rst_err",   32'(err),   32'd0);
    @(posedge clk); #1 reset = 1'b0;
    run_instr(6'h00, 6'h08, 1'b0, 0, 0);
    check("post_err_jr_cycles", 32'(r_cycles), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "simulation time limit");
  end

endmodule
